pair_buffer4: RTL
=================

PAIR_BUFFER4 -- requirements
Module: pair_buffer4

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, bit width of each input word and each output operand.
REQ-002 SHALL provide ports (clock and reset first):
- CLK  input  1  rising-edge clock
- ASYNCRESET  input  1  asynchronous, active-high reset
- I  input  WIDTH  input word stream
- I_valid  input  1  I carries a word
- I_ready  output  1  block accepts I this cycle
- flush  input  1  synchronous discard of a half-formed pair
- O0  output  WIDTH  first operand of head pair (drives downstream I0)
- O1  output  WIDTH  second operand of head pair (drives downstream I1)
- O_valid  output  1  head pair present
- O_ready  input  1  downstream consumes head pair
- count  output  2  stored complete pairs, 0..2
- half  output  1  first word of a pair is held
REQ-003 SHALL use one clock, CLK; reset SHALL be asynchronous and active-high on ASYNCRESET.

Function
REQ-004 Input transfer SHALL occur on a CLK edge where I_valid=1 and I_ready=1; output transfer SHALL occur where O_valid=1 and O_ready=1.
REQ-005 Pairing state SHALL have two states: EMPTY (half=0) and HELD (half=1).
REQ-006 EMPTY + input transfer SHALL store I in the hold register and move to HELD, regardless of count.
REQ-007 HELD + input transfer SHALL push pair {O0=held word, O1=I} into the pair FIFO and return to EMPTY.
REQ-008 Pair FIFO SHALL be 2 entries deep, strictly first-in first-out; read and write pointers SHALL be 1 bit and wrap modulo 2.
REQ-009 I_ready SHALL be 0 when flush=1; otherwise it SHALL be 1 when half=0, or when half=1 and count<2. I_ready SHALL NOT depend on O_ready.
REQ-010 O_valid SHALL equal (count!=0); O0/O1 SHALL show the head entry and remain stable while O_valid=1 and O_ready=0.
REQ-011 Latency: a pair SHALL appear on O0/O1 with O_valid=1 on the cycle after the handshake of its second word.
REQ-012 Simultaneous push and pop SHALL leave count unchanged and preserve order; a push at count=2 cannot occur (REQ-009).
REQ-013 Pop at count=1 with no push SHALL set count=0 and O_valid=0 next cycle; O0/O1 then hold their last values.
REQ-014 flush=1 SHALL set half=0 at the next edge and discard the held word; FIFO contents, count and pops SHALL be unaffected.
REQ-015 O_ready while O_valid=0 SHALL have no effect.

Reset
REQ-016 ASYNCRESET=1 SHALL immediately, without a CLK edge, force half=0, count=0, O_valid=0, O0=0, O1=0, both pointers=0 and hold register=0; I_ready SHALL then be 1 whenever flush=0.
REQ-017 Reset asserted mid-operation SHALL discard all held words and stored pairs; none SHALL appear after deassertion.
REQ-018 The first CLK edge after deassertion SHALL be able to perform an input transfer.

Verification
REQ-019 Scenario reset: fill to count=2, half=1, then pulse ASYNCRESET between edges -> O_valid=0, count=0, half=0, O0=O1=0 before the next edge; I_ready=1.
REQ-020 Scenario basic pair: O_ready=0; send 0x3 then 0x5 -> next cycle O_valid=1, O0=0x3, O1=0x5, count=1; downstream AND yields 0x1.
REQ-021 Scenario full/backpressure: O_ready=0; send 0x1,0x2,0x3,0x4,0x5 -> count=2, half=1 (0x5 held), I_ready=0; then O_ready=1 -> pops (0x1,0x2), then (0x3,0x4); I_ready returns to 1 after the first pop.
REQ-022 Scenario simultaneous push/pop: count=1 holding (0xA,0xB), half=1 holding 0xC, O_ready=1, send 0xD -> count stays 1; next head (0xC,0xD).
REQ-023 Scenario flush: half=1 holding 0x9, assert flush one cycle with I_valid=1 -> I_ready=0 that cycle, half=0 next; then send 0x6,0xF -> pair (0x6,0xF); 0x9 never output.
REQ-024 Scenario hold stability: O_valid=1, O_ready=0 for 10 cycles with random I traffic -> O0/O1 unchanged throughout.

Source files
------------

// File: rtl/pair_buffer4.sv
// Pairs consecutive input words into {O0,O1} operands and queues up to two
// complete pairs in a 2-entry FIFO ahead of a two-input downstream operator.
module pair_buffer4 #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [1:0]       count,
  output logic             half
);

  logic             r_half;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_mem0 [2];
  logic [WIDTH-1:0] r_mem1 [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  logic             w_in_xfer;
  logic             w_push;
  logic             w_pop;
  logic             w_show;

  assign I_ready   = !flush && (!r_half || (r_count != 2'd2));
  assign O_valid   = (r_count != 2'd0);
  assign w_in_xfer = I_valid && I_ready;
  assign w_push    = w_in_xfer && r_half;
  assign w_pop     = O_valid && O_ready;

  // When empty, the slot behind the read pointer still holds the last popped
  // pair, and a push always lands on the read pointer, so it is never
  // overwritten while displayed.
  assign w_show = O_valid ? r_rptr : ~r_rptr;
  assign O0     = r_mem0[w_show];
  assign O1     = r_mem1[w_show];
  assign count  = r_count;
  assign half   = r_half;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_half    <= 1'b0;
      r_hold    <= '0;
      r_mem0[0] <= '0;
      r_mem0[1] <= '0;
      r_mem1[0] <= '0;
      r_mem1[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (flush) begin
        r_half <= 1'b0;
      end else if (w_in_xfer) begin
        if (r_half) begin
          r_mem0[r_wptr] <= r_hold;
          r_mem1[r_wptr] <= I;
          r_wptr         <= ~r_wptr;
          r_half         <= 1'b0;
        end else begin
          r_hold <= I;
          r_half <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
